// File: rtl/fft_pkg.sv
// Shared FFT constants, bank state encoding and index helpers.
// Used by the sample loader and the downstream FFT stages.
package fft_pkg;

    localparam int N_POINTS = 32;
    localparam int IDX_W    = 5;
    localparam int DATA_W   = 32;
    localparam int CPLX_W   = 2 * DATA_W;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = idx[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream and frame hand-off signals of the FFT sample loader.
// slave = loader side, master = producer / stage-0 side.
interface fft_sample_loader_if;
    import fft_pkg::*;

    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_W-1:0]            s_data;
    logic                         s_last;
    logic                         frame_valid;
    logic [N_POINTS*CPLX_W-1:0]   frame_data;
    logic                         frame_padded;
    logic                         frame_ack;

    modport master (
        output s_valid, s_data, s_last, frame_ack,
        input  s_ready, frame_valid, frame_data, frame_padded
    );

    modport slave (
        input  s_valid, s_data, s_last, frame_ack,
        output s_ready, frame_valid, frame_data, frame_padded
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One ping-pong frame bank: N_POINTS x DATA_W registers, write port,
// synchronous clear and pad flag, with flat read-out.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           widx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       clr_i,
    input  logic                       pad_set_i,
    output logic [N_POINTS*DATA_W-1:0] data_o,
    output logic                       pad_o
);

    logic [DATA_W-1:0] mem_q [N_POINTS];
    logic              pad_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_POINTS; i++) mem_q[i] <= '0;
            pad_q <= 1'b0;
        end else if (clr_i) begin
            // Clearing on release is what zero-fills the tail of short frames
            for (int i = 0; i < N_POINTS; i++) mem_q[i] <= '0;
            pad_q <= 1'b0;
        end else begin
            if (we_i)      mem_q[widx_i] <= wdata_i;
            if (pad_set_i) pad_q <= 1'b1;
        end
    end

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            data_o[k*DATA_W +: DATA_W] = mem_q[k];
        end
    end

    assign pad_o = pad_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Streams real samples into ping-pong frame banks for FFT stage 0.
// Define BITREV_EN to store samples in bit-reversed entry order.
module fft_sample_loader
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    fft_sample_loader_if.slave bus
);

    logic [1:0]       state_q [2];
    logic [1:0]       state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

    logic             accept, close, release_b, last_idx;
    logic             valid;
    logic [IDX_W-1:0] widx;
    logic [N_POINTS*DATA_W-1:0] d0, d1, sel;
    logic             p0, p1;

    assign bus.s_ready = (state_q[wr_bank_q] != ST_FULL);
    assign valid       = (state_q[rd_bank_q] == ST_FULL);
    assign last_idx    = (wr_idx_q == IDX_W'(N_POINTS - 1));
    assign accept      = bus.s_valid & bus.s_ready;
    assign close       = accept & (last_idx | bus.s_last);
    assign release_b   = bus.frame_ack & valid;

`ifdef BITREV_EN
    assign widx = bitrev(wr_idx_q);
`else
    assign widx = wr_idx_q;
`endif

    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (state_q[wr_bank_q] == ST_EMPTY) state_d[wr_bank_q] = ST_FILLING;
            if (close) begin
                state_d[wr_bank_q] = ST_FULL;
                wr_bank_d          = ~wr_bank_q;
                wr_idx_d           = '0;
            end
        end
        // Close and release always target different banks
        if (release_b) begin
            state_d[rd_bank_q] = ST_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q[0] <= ST_EMPTY;
            state_q[1] <= ST_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    fft_frame_bank u_bank0 (
        .clk       (clk),
        .reset     (reset),
        .we_i      (accept & ~wr_bank_q),
        .widx_i    (widx),
        .wdata_i   (bus.s_data),
        .clr_i     (release_b & ~rd_bank_q),
        .pad_set_i (close & ~last_idx & ~wr_bank_q),
        .data_o    (d0),
        .pad_o     (p0)
    );

    fft_frame_bank u_bank1 (
        .clk       (clk),
        .reset     (reset),
        .we_i      (accept & wr_bank_q),
        .widx_i    (widx),
        .wdata_i   (bus.s_data),
        .clr_i     (release_b & rd_bank_q),
        .pad_set_i (close & ~last_idx & wr_bank_q),
        .data_o    (d1),
        .pad_o     (p1)
    );

    assign sel              = rd_bank_q ? d1 : d0;
    assign bus.frame_valid  = valid;
    assign bus.frame_padded = valid & (rd_bank_q ? p1 : p0);

    always_comb begin
        bus.frame_data = '0;
        if (valid) begin
            for (int k = 0; k < N_POINTS; k++) begin
                bus.frame_data[k*CPLX_W +: CPLX_W] =
                    {sel[k*DATA_W +: DATA_W], {DATA_W{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed scoreboard bench for fft_sample_loader.
// Honours BITREV_EN in its own reference model.
module tb_fft_sample_loader;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fft_sample_loader_if bus ();

    fft_sample_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1023:0] exp_q [$];
    bit            pad_q [$];
    logic [1023:0] m_frame;
    int            m_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f2b(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic int entry_of(input int n);
        logic [4:0] i5;
        logic [4:0] r5;
        i5 = 5'(n);
`ifdef BITREV_EN
        r5 = {<<{i5}};
`else
        r5 = i5;
`endif
        return int'(r5);
    endfunction

    task automatic model_accept(input logic [31:0] d, input bit last);
        m_frame[32*entry_of(m_idx) +: 32] = d;
        if (m_idx == 31 || last) begin
            exp_q.push_back(m_frame);
            pad_q.push_back(m_idx != 31);
            m_frame = '0;
            m_idx   = 0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic push(input logic [31:0] d, input bit last);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.s_ready) chk("push_timeout", bus.s_ready, 1);
        else model_accept(d, last);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        @(posedge clk); #1;
        bus.frame_ack = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int n;
        logic [1023:0] ed;
        bit ep;
        n = 0;
        while (!bus.frame_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, bus.frame_valid, 1);
        chk({tag, "_sb"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            ed = exp_q.pop_front();
            ep = pad_q.pop_front();
            chk({tag, "_pad"}, bus.frame_padded, ep);
            for (int k = 0; k < 32; k++) begin
                chk($sformatf("%s_e%0d", tag, k), bus.frame_data[64*k +: 64],
                    {ed[32*k +: 32], 32'h0});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_frame = '0;
        m_idx   = 0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.frame_ack = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.s_ready, 1);
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_pad", bus.frame_padded, 0);
        chk("rst_data", |bus.frame_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        ack();
        chk("ign_ack_valid", bus.frame_valid, 0);
        chk("ign_ack_ready", bus.s_ready, 1);

        // full frame, natural values 1..32
        for (int i = 0; i < 31; i++) push(f2b(i + 1), 1'b0);
        chk("t1_pre_valid", bus.frame_valid, 0);
        push(f2b(32), 1'b0);
        chk("t1_latency", bus.frame_valid, 1);
        check_frame("t1");
        ack();
        chk("t1_post_ack", bus.frame_valid, 0);

        // back-pressure
        for (int i = 0; i < 64; i++) push(f2b(100 + i), 1'b0);
        chk("t2_bp_ready", bus.s_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_bp_hold", bus.s_ready, 0);
        check_frame("t2a");
        ack();
        chk("t2_ready_after_ack", bus.s_ready, 1);
        push(f2b(164), 1'b0);
        check_frame("t2b");
        ack();
        for (int i = 65; i < 96; i++) push(f2b(100 + i), 1'b0);
        check_frame("t2c");
        ack();

        // early close
        for (int i = 0; i < 4; i++) push(32'h3F800000, 1'b0);
        push(32'h3F800000, 1'b1);
        chk("t3_pad_raw", bus.frame_padded, 1);
        check_frame("t3");
        ack();

        // close and ack in the same cycle
        for (int i = 0; i < 32; i++) push(f2b(200 + i), 1'b0);
        check_frame("t4a");
        for (int i = 0; i < 31; i++) push(f2b(i + 7), 1'b0);
        bus.frame_ack = 1'b1;
        push(f2b(99), 1'b0);
        bus.frame_ack = 1'b0;
        chk("t4_no_gap", bus.frame_valid, 1);
        chk("t4_b0_empty", bus.s_ready, 1);
        check_frame("t4b");
        ack();

        // mid-frame reset
        for (int i = 0; i < 17; i++) push(f2b(50 + i), 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_rst_ready", bus.s_ready, 1);
        chk("t5_rst_valid", bus.frame_valid, 0);
        chk("t5_rst_pad", bus.frame_padded, 0);
        chk("t5_rst_data", |bus.frame_data, 0);
        m_frame = '0;
        m_idx   = 0;
        exp_q.delete();
        pad_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) push(f2b(i), 1'b0);
        check_frame("t5");
        ack();
        chk("t5_end_valid", bus.frame_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
